// File: rtl/serial_word_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_receiver_if
//  Purpose  : Bundles the serial-link input side and the parallel-word output
//             handshake of serial_word_receiver into one interface.
//  Signals  : Enable_In, Serial_Data_In, Serial_Valid_In, Frame_Start_In,
//             Shift_Direction_In, Parallel_Ready_In, Error_Clear_In
//             (driven by the master)
//             Parallel_Data_Out, Parallel_Valid_Out, Bit_Count_Out, Busy_Out,
//             Overrun_Error_Out, Framing_Error_Out (driven by the slave)
//  Modports : master = link source / word consumer, slave = the receiver
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_word_receiver_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic                  Enable_In;
   logic                  Serial_Data_In;
   logic                  Serial_Valid_In;
   logic                  Frame_Start_In;
   logic                  Shift_Direction_In;
   logic [DATA_WIDTH-1:0] Parallel_Data_Out;
   logic                  Parallel_Valid_Out;
   logic                  Parallel_Ready_In;
   logic [CNT_W-1:0]      Bit_Count_Out;
   logic                  Busy_Out;
   logic                  Overrun_Error_Out;
   logic                  Framing_Error_Out;
   logic                  Error_Clear_In;

   modport master (
      output Enable_In, Serial_Data_In, Serial_Valid_In, Frame_Start_In,
             Shift_Direction_In, Parallel_Ready_In, Error_Clear_In,
      input  Parallel_Data_Out, Parallel_Valid_Out, Bit_Count_Out, Busy_Out,
             Overrun_Error_Out, Framing_Error_Out
   );

   modport slave (
      input  Enable_In, Serial_Data_In, Serial_Valid_In, Frame_Start_In,
             Shift_Direction_In, Parallel_Ready_In, Error_Clear_In,
      output Parallel_Data_Out, Parallel_Valid_Out, Bit_Count_Out, Busy_Out,
             Overrun_Error_Out, Framing_Error_Out
   );
endinterface
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_receiver
//  Purpose  : Receive end of a serial link. Samples a bit stream (MSB-first or
//             LSB-first, chosen per frame) and assembles DATA_WIDTH-bit words.
//             A completed word moves into an output holding register behind a
//             valid/ready handshake while the shift register keeps filling.
//             Sticky overrun and framing error flags.
//  Ports    : Clk_In   - clock, all state updates on posedge
//             Reset_In - synchronous active-low reset
//             bus      - serial_word_receiver_if.slave (link + word handshake)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_word_receiver #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   serial_word_receiver_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RECEIVE = 1'b1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   logic [0:0]            state_q,   state_d;
   logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
   logic [DATA_WIDTH-1:0] dout_q,    dout_d;
   logic                  valid_q,   valid_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  dir_q,     dir_d;
   logic                  ovr_q,     ovr_d;
   logic                  frm_q,     frm_d;

   logic                  accept;
   logic                  start;
   logic                  take_bit;
   logic                  word_done;
   logic                  handshake;
   logic                  can_load;
   logic [DATA_WIDTH-1:0] shifted;

   // A Frame_Start bit always opens a new frame, in either state; an ordinary
   // bit only counts while a frame is open.
   assign accept    = bus.Enable_In & bus.Serial_Valid_In;
   assign start     = accept & bus.Frame_Start_In;
   assign take_bit  = accept & ~bus.Frame_Start_In & (state_q == ST_RECEIVE);
   assign word_done = take_bit & (cnt_q == LAST_CNT);
   assign handshake = valid_q & bus.Parallel_Ready_In;
   // Holding register is free if empty or being drained at this very edge.
   assign can_load  = ~valid_q | bus.Parallel_Ready_In;

   assign shifted = dir_q ? {bus.Serial_Data_In, shreg_q[DATA_WIDTH-1:1]}
                          : {shreg_q[DATA_WIDTH-2:0], bus.Serial_Data_In};

   // ------------------------------------------------------------------------
   // State register (plus datapath flops)
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk_In) begin
      if (!Reset_In) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         ovr_q   <= 1'b0;
         frm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         ovr_q   <= ovr_d;
         frm_q   <= frm_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      dout_d  = dout_q;
      valid_d = valid_q;

      if (start) begin
         state_d = ST_RECEIVE;
         dir_d   = bus.Shift_Direction_In;
         cnt_d   = CNT_W'(1);
         // Any partial word is discarded: the new frame starts from zero.
         shreg_d = '0;
         if (bus.Shift_Direction_In) begin
            shreg_d[DATA_WIDTH-1] = bus.Serial_Data_In;
         end else begin
            shreg_d[0] = bus.Serial_Data_In;
         end
      end else if (take_bit) begin
         shreg_d = shifted;
         if (word_done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (handshake) begin
         valid_d = 1'b0;
      end
      // A completion coinciding with a transfer reloads without a bubble;
      // one arriving while the held word is stalled is dropped.
      if (word_done && can_load) begin
         dout_d  = shifted;
         valid_d = 1'b1;
      end

      // Set wins over clear.
      ovr_d = (word_done & ~can_load) | (ovr_q & ~bus.Error_Clear_In);
      frm_d = (start & (state_q == ST_RECEIVE)) | (frm_q & ~bus.Error_Clear_In);
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      bus.Busy_Out           = (state_q == ST_RECEIVE);
      bus.Parallel_Data_Out  = dout_q;
      bus.Parallel_Valid_Out = valid_q;
      bus.Bit_Count_Out      = cnt_q;
      bus.Overrun_Error_Out  = ovr_q;
      bus.Framing_Error_Out  = frm_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_word_receiver
//  Purpose  : Directed self-checking bench for serial_word_receiver
//             (DATA_WIDTH = 32). Inputs change #1 after posedge, outputs are
//             checked at the same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_receiver;
   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] w2, w3, w4a, w4b, w5a, w5b, w6a, w6b, w7a, w7b, w7c, w7d;

   serial_word_receiver_if #(.DATA_WIDTH(32)) bus ();

   serial_word_receiver #(.DATA_WIDTH(32)) dut (
      .Clk_In   (clk),
      .Reset_In (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends stream positions first..first+n-1 of word w; position 0 carries
   // Frame_Start. dir 0 = MSB first, 1 = LSB first.
   task automatic send_bits(input logic [31:0] w, input logic d, input int first, input int n);
      for (int p = first; p < first + n; p++) begin
         bus.Enable_In          = 1'b1;
         bus.Serial_Valid_In    = 1'b1;
         bus.Shift_Direction_In = d;
         bus.Frame_Start_In     = (p == 0);
         bus.Serial_Data_In     = d ? w[p] : w[31-p];
         tick();
      end
   endtask

   task automatic idle();
      bus.Serial_Valid_In = 1'b0;
      bus.Frame_Start_In  = 1'b0;
      tick();
   endtask

   initial begin
      w2  = 32'hA5A5_0F0F;
      w3  = 32'h1234_5678;
      w4a = 32'hDEAD_BEEF;
      w4b = 32'hCAFE_F00D;
      w5a = 32'hFFFF_FFFF;
      w5b = 32'h0000_FFFF;
      w6a = 32'h1111_2222;
      w6b = 32'h3333_4444;
      w7a = 32'h55AA_55AA;
      w7b = 32'h0000_0007;
      w7c = 32'h9876_5432;
      w7d = 32'h0F1E_2D3C;

      rst_n                  = 1'b0;
      bus.Enable_In          = 1'b0;
      bus.Serial_Data_In     = 1'b0;
      bus.Serial_Valid_In    = 1'b0;
      bus.Frame_Start_In     = 1'b0;
      bus.Shift_Direction_In = 1'b0;
      bus.Parallel_Ready_In  = 1'b0;
      bus.Error_Clear_In     = 1'b0;

      // ---- Reset state
      tick();
      tick();
      chk("rst_data",  64'(bus.Parallel_Data_Out), 64'h0);
      chk("rst_valid", 64'(bus.Parallel_Valid_Out), 64'h0);
      chk("rst_cnt",   64'(bus.Bit_Count_Out), 64'h0);
      chk("rst_busy",  64'(bus.Busy_Out), 64'h0);
      chk("rst_ovr",   64'(bus.Overrun_Error_Out), 64'h0);
      chk("rst_frm",   64'(bus.Framing_Error_Out), 64'h0);
      rst_n = 1'b1;
      tick();

      // ---- MSB-first frame, ready=1
      bus.Parallel_Ready_In = 1'b1;
      send_bits(w2, 1'b0, 0, 1);
      chk("msb_busy_b0", 64'(bus.Busy_Out), 64'h1);
      chk("msb_cnt_b0",  64'(bus.Bit_Count_Out), 64'h1);
      send_bits(w2, 1'b0, 1, 30);
      chk("msb_cnt_b30", 64'(bus.Bit_Count_Out), 64'd31);
      chk("msb_valid_pre", 64'(bus.Parallel_Valid_Out), 64'h0);
      send_bits(w2, 1'b0, 31, 1);
      chk("msb_valid", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("msb_data",  64'(bus.Parallel_Data_Out), 64'hA5A5_0F0F);
      chk("msb_cnt",   64'(bus.Bit_Count_Out), 64'h0);
      chk("msb_busy",  64'(bus.Busy_Out), 64'h0);
      idle();
      chk("msb_valid_1cyc", 64'(bus.Parallel_Valid_Out), 64'h0);

      // ---- LSB-first frame with gaps; direction input toggled after bit 0
      for (int i = 0; i < 32; i++) begin
         bus.Enable_In          = 1'b1;
         bus.Serial_Valid_In    = 1'b1;
         bus.Frame_Start_In     = (i == 0);
         bus.Shift_Direction_In = (i == 0);
         bus.Serial_Data_In     = w3[i];
         tick();
         if (i == 16) begin
            // Disabled with a would-be restart strobe: must be ignored.
            bus.Enable_In      = 1'b0;
            bus.Frame_Start_In = 1'b1;
            repeat (5) tick();
            chk("lsb_dis_cnt",  64'(bus.Bit_Count_Out), 64'd17);
            chk("lsb_dis_busy", 64'(bus.Busy_Out), 64'h1);
         end
         if (i < 31) begin
            bus.Enable_In       = 1'b1;
            bus.Serial_Valid_In = 1'b0;
            bus.Frame_Start_In  = 1'b1;
            bus.Serial_Data_In  = ~bus.Serial_Data_In;
            tick();
            chk("lsb_gap_cnt", 64'(bus.Bit_Count_Out), 64'(i + 1));
         end
      end
      chk("lsb_valid", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("lsb_data",  64'(bus.Parallel_Data_Out), 64'h1234_5678);
      chk("lsb_cnt",   64'(bus.Bit_Count_Out), 64'h0);
      chk("lsb_frm",   64'(bus.Framing_Error_Out), 64'h0);
      idle();
      chk("lsb_drain", 64'(bus.Parallel_Valid_Out), 64'h0);

      // ---- Backpressure and overrun
      bus.Parallel_Ready_In = 1'b0;
      send_bits(w4a, 1'b0, 0, 32);
      chk("bp_valid1", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("bp_data1",  64'(bus.Parallel_Data_Out), 64'hDEAD_BEEF);
      chk("bp_ovr0",   64'(bus.Overrun_Error_Out), 64'h0);
      send_bits(w4b, 1'b0, 0, 32);
      chk("bp_valid2", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("bp_hold",   64'(bus.Parallel_Data_Out), 64'hDEAD_BEEF);
      chk("bp_ovr",    64'(bus.Overrun_Error_Out), 64'h1);
      chk("bp_frm",    64'(bus.Framing_Error_Out), 64'h0);
      idle();
      chk("bp_stable", 64'(bus.Parallel_Data_Out), 64'hDEAD_BEEF);
      chk("bp_vhold",  64'(bus.Parallel_Valid_Out), 64'h1);
      bus.Parallel_Ready_In = 1'b1;
      idle();
      chk("bp_xfer",   64'(bus.Parallel_Valid_Out), 64'h0);
      idle();
      chk("bp_once",   64'(bus.Parallel_Valid_Out), 64'h0);
      chk("bp_ovr_sticky", 64'(bus.Overrun_Error_Out), 64'h1);
      bus.Error_Clear_In = 1'b1;
      idle();
      bus.Error_Clear_In = 1'b0;
      chk("bp_ovr_clr", 64'(bus.Overrun_Error_Out), 64'h0);

      // ---- Frame restart at bit 10
      send_bits(w5a, 1'b0, 0, 10);
      chk("rs_cnt10", 64'(bus.Bit_Count_Out), 64'd10);
      send_bits(w5b, 1'b0, 0, 1);
      chk("rs_frm",   64'(bus.Framing_Error_Out), 64'h1);
      chk("rs_cnt1",  64'(bus.Bit_Count_Out), 64'h1);
      send_bits(w5b, 1'b0, 1, 31);
      chk("rs_valid", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("rs_data",  64'(bus.Parallel_Data_Out), 64'h0000_FFFF);
      chk("rs_ovr",   64'(bus.Overrun_Error_Out), 64'h0);
      idle();
      bus.Error_Clear_In = 1'b1;
      idle();
      bus.Error_Clear_In = 1'b0;
      chk("rs_frm_clr", 64'(bus.Framing_Error_Out), 64'h0);

      // ---- Completion coinciding with handshake
      bus.Parallel_Ready_In = 1'b0;
      send_bits(w6a, 1'b0, 0, 32);
      chk("b2b_valid1", 64'(bus.Parallel_Valid_Out), 64'h1);
      send_bits(w6b, 1'b0, 0, 31);
      chk("b2b_valid_mid", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("b2b_data_mid",  64'(bus.Parallel_Data_Out), 64'h1111_2222);
      chk("b2b_cnt31",     64'(bus.Bit_Count_Out), 64'd31);
      bus.Parallel_Ready_In = 1'b1;
      send_bits(w6b, 1'b0, 31, 1);
      chk("b2b_valid2", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("b2b_data2",  64'(bus.Parallel_Data_Out), 64'h3333_4444);
      chk("b2b_ovr",    64'(bus.Overrun_Error_Out), 64'h0);
      idle();
      chk("b2b_drain",  64'(bus.Parallel_Valid_Out), 64'h0);

      // ---- Reset mid-frame with a pending word and a set flag
      bus.Parallel_Ready_In = 1'b0;
      send_bits(w7a, 1'b0, 0, 32);
      send_bits(w7b, 1'b0, 0, 3);
      send_bits(w7c, 1'b0, 0, 17);
      chk("mr_cnt",   64'(bus.Bit_Count_Out), 64'd17);
      chk("mr_busy",  64'(bus.Busy_Out), 64'h1);
      chk("mr_frm",   64'(bus.Framing_Error_Out), 64'h1);
      chk("mr_valid", 64'(bus.Parallel_Valid_Out), 64'h1);
      rst_n = 1'b0;
      send_bits(w7c, 1'b0, 17, 1);
      rst_n = 1'b1;
      chk("mr_r_valid", 64'(bus.Parallel_Valid_Out), 64'h0);
      chk("mr_r_busy",  64'(bus.Busy_Out), 64'h0);
      chk("mr_r_cnt",   64'(bus.Bit_Count_Out), 64'h0);
      chk("mr_r_frm",   64'(bus.Framing_Error_Out), 64'h0);
      chk("mr_r_ovr",   64'(bus.Overrun_Error_Out), 64'h0);
      chk("mr_r_data",  64'(bus.Parallel_Data_Out), 64'h0);
      bus.Parallel_Ready_In = 1'b1;
      send_bits(w7d, 1'b1, 0, 32);
      chk("mr_valid2", 64'(bus.Parallel_Valid_Out), 64'h1);
      chk("mr_data2",  64'(bus.Parallel_Data_Out), 64'h0F1E_2D3C);
      chk("mr_frm2",   64'(bus.Framing_Error_Out), 64'h0);
      idle();
      chk("mr_drain",  64'(bus.Parallel_Valid_Out), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
